// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-stage data access controller with wait states, timeout abort and writeback register
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WEN_M,
  input  logic          DRW_M,
  input  logic          DREQ_M,
  input  logic [1:0]    SelWB_M,
  input  logic [4:0]    WA_M,
  input  logic [31:0]   PCADD4_M,
  input  logic [31:0]   ALUOUT_M,
  input  logic [31:0]   DOUT0_M,
  output logic          DREQ,
  output logic          DRW,
  output logic [AW-1:0] DADDR,
  output logic [31:0]   DOUT,
  input  logic [31:0]   DI,
  input  logic          DRDY,
  output logic          STALL_M,
  output logic          BUS_ERR,
  output logic          WEN_W,
  output logic [1:0]    SelWB_W,
  output logic [4:0]    WA_W,
  output logic [31:0]   PCADD4_W,
  output logic [31:0]   ALUOUT_W,
  output logic [31:0]   MDR_W
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  // Copy of the stalled access; upstream may change the *_M inputs while we wait.
  logic          wen_l;
  logic          drw_l;
  logic [1:0]    selwb_l;
  logic [4:0]    wa_l;
  logic [31:0]   pcadd4_l;
  logic [31:0]   aluout_l;
  logic [31:0]   dout_l;

  logic          capture;
  logic          complete;
  logic          abort;
  logic          stall;
  logic          dreq_c;
  logic          drw_c;
  logic [AW-1:0] daddr_c;
  logic [31:0]   dout_c;

  logic          wb_wen;
  logic [1:0]    wb_selwb;
  logic [4:0]    wb_wa;
  logic [31:0]   wb_pcadd4;
  logic [31:0]   wb_aluout;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    dreq_c       = 1'b1;
    drw_c        = DRW_M;
    daddr_c      = ALUOUT_M[AW-1:0];
    dout_c       = DOUT0_M;
    stall        = 1'b0;
    capture      = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        dreq_c = DREQ_M;
        if (!DREQ_M) begin
          if (DRDY) begin
            complete = 1'b1;
          end else begin
            stall        = 1'b1;
            capture      = 1'b1;
            state_nxt    = WAIT;
            wait_cnt_nxt = '0;
          end
        end
      end
      WAIT: begin
        dreq_c  = 1'b0;
        drw_c   = drw_l;
        daddr_c = aluout_l[AW-1:0];
        dout_c  = dout_l;
        if (DRDY) begin
          complete     = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          // Give up: release the bus and let the pipeline move on with a bubble.
          abort        = 1'b1;
          dreq_c       = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          stall        = 1'b1;
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
    if (RST) begin
      dreq_c = 1'b1;
      stall  = 1'b0;
    end
  end

  assign DREQ    = dreq_c;
  assign DRW     = drw_c;
  assign DADDR   = daddr_c;
  assign DOUT    = dout_c;
  assign STALL_M = stall;

  always_comb begin
    if (state == WAIT) begin
      wb_wen    = wen_l;
      wb_selwb  = selwb_l;
      wb_wa     = wa_l;
      wb_pcadd4 = pcadd4_l;
      wb_aluout = aluout_l;
    end else begin
      wb_wen    = WEN_M;
      wb_selwb  = SelWB_M;
      wb_wa     = WA_M;
      wb_pcadd4 = PCADD4_M;
      wb_aluout = ALUOUT_M;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      BUS_ERR  <= 1'b0;
      WEN_W    <= 1'b1;
      SelWB_W  <= '0;
      WA_W     <= '0;
      PCADD4_W <= '0;
      ALUOUT_W <= '0;
      MDR_W    <= '0;
      wen_l    <= 1'b1;
      drw_l    <= 1'b0;
      selwb_l  <= '0;
      wa_l     <= '0;
      pcadd4_l <= '0;
      aluout_l <= '0;
      dout_l   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (capture) begin
        wen_l    <= WEN_M;
        drw_l    <= DRW_M;
        selwb_l  <= SelWB_M;
        wa_l     <= WA_M;
        pcadd4_l <= PCADD4_M;
        aluout_l <= ALUOUT_M;
        dout_l   <= DOUT0_M;
      end
      if (abort) begin
        BUS_ERR <= 1'b1;
      end
      if (stall) begin
        WEN_W <= 1'b1;
      end else begin
        WEN_W    <= abort ? 1'b1 : wb_wen;
        SelWB_W  <= wb_selwb;
        WA_W     <= wb_wa;
        PCADD4_W <= wb_pcadd4;
        ALUOUT_W <= wb_aluout;
        if (abort) begin
          MDR_W <= 32'h0;
        end else if (complete && !drw_c) begin
          MDR_W <= DI;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction-level model
module tb_mem_access;

  localparam int TO = 4;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WEN_M, DRW_M, DREQ_M;
  logic [1:0]    SelWB_M;
  logic [4:0]    WA_M;
  logic [31:0]   PCADD4_M, ALUOUT_M, DOUT0_M, DI;
  logic          DRDY;
  logic          DREQ, DRW, STALL_M, BUS_ERR, WEN_W;
  logic [AW-1:0] DADDR;
  logic [31:0]   DOUT, PCADD4_W, ALUOUT_W, MDR_W;
  logic [1:0]    SelWB_W;
  logic [4:0]    WA_W;

  always #5 CLK = ~CLK;

  mem_access #(.TIMEOUT(TO), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .WEN_M(WEN_M), .DRW_M(DRW_M), .DREQ_M(DREQ_M),
    .SelWB_M(SelWB_M), .WA_M(WA_M), .PCADD4_M(PCADD4_M), .ALUOUT_M(ALUOUT_M),
    .DOUT0_M(DOUT0_M), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DOUT(DOUT),
    .DI(DI), .DRDY(DRDY), .STALL_M(STALL_M), .BUS_ERR(BUS_ERR), .WEN_W(WEN_W),
    .SelWB_W(SelWB_W), .WA_W(WA_W), .PCADD4_W(PCADD4_W), .ALUOUT_W(ALUOUT_W),
    .MDR_W(MDR_W)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_stall = 0;
  int n_wb = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding access record plus the expected writeback contents.
  typedef struct {
    logic        wen;
    logic        drw;
    logic [1:0]  sel;
    logic [4:0]  wa;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] dout;
  } acc_t;

  bit          busy = 0;
  int          waits = 0;
  acc_t        acc;
  logic        e_wen, e_err;
  logic [1:0]  e_sel;
  logic [4:0]  e_wa;
  logic [31:0] e_pc, e_alu, e_mdr;

  task automatic cycle();
    logic  x_dreq, x_stall, x_abort, x_done;
    bit    bus_valid;
    acc_t  cur, src;
    #2;
    cur = '{WEN_M, DRW_M, SelWB_M, WA_M, PCADD4_M, ALUOUT_M, DOUT0_M};
    x_abort   = 0;
    bus_valid = 0;
    if (RST) begin
      x_dreq  = 1;
      x_stall = 0;
      x_done  = 0;
      src     = cur;
    end else if (!busy) begin
      src       = cur;
      x_dreq    = DREQ_M;
      bus_valid = !DREQ_M;
      x_stall   = !DREQ_M && !DRDY;
      x_done    = !DREQ_M && DRDY;
    end else begin
      src       = acc;
      bus_valid = 1;
      x_done    = DRDY;
      x_abort   = !DRDY && waits == TO;
      x_dreq    = x_abort;
      x_stall   = !DRDY && !x_abort;
    end
    check("DREQ", 32'(DREQ), 32'(x_dreq));
    check("STALL_M", 32'(STALL_M), 32'(x_stall));
    if (bus_valid) begin
      check("DRW", 32'(DRW), 32'(src.drw));
      check("DADDR", DADDR, src.alu);
      check("DOUT", DOUT, src.dout);
    end
    if (x_stall) n_stall++;
    @(posedge CLK);
    if (RST) begin
      busy = 0; e_err = 0; e_wen = 1; e_sel = 0; e_wa = 0;
      e_pc = 0; e_alu = 0; e_mdr = 0;
    end else if (x_stall) begin
      e_wen = 1;
      if (!busy) begin
        busy = 1; waits = 0; acc = cur;
      end else begin
        waits++;
      end
    end else begin
      n_wb++;
      e_wen = x_abort ? 1'b1 : src.wen;
      e_sel = src.sel; e_wa = src.wa; e_pc = src.pc4; e_alu = src.alu;
      if (x_abort) begin
        e_mdr = 0;
        e_err = 1;
      end else if (x_done && !src.drw) begin
        e_mdr = DI;
      end
      busy = 0;
    end
    #1;
    check("BUS_ERR", 32'(BUS_ERR), 32'(e_err));
    check("WEN_W", 32'(WEN_W), 32'(e_wen));
    check("SelWB_W", 32'(SelWB_W), 32'(e_sel));
    check("WA_W", 32'(WA_W), 32'(e_wa));
    check("PCADD4_W", PCADD4_W, e_pc);
    check("ALUOUT_W", ALUOUT_W, e_alu);
    check("MDR_W", MDR_W, e_mdr);
  endtask

  task automatic set_in(input logic dreq, input logic drw, input logic [31:0] alu,
                        input logic [31:0] dout, input logic wen, input logic drdy,
                        input logic [31:0] di);
    DREQ_M = dreq; DRW_M = drw; ALUOUT_M = alu; DOUT0_M = dout; WEN_M = wen;
    DRDY = drdy; DI = di;
    SelWB_M = 2'($urandom); WA_M = 5'($urandom); PCADD4_M = $urandom;
  endtask

  task automatic scramble_m();
    set_in(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), DRDY, $urandom);
  endtask

  int stuck;

  initial begin
    RST = 1;
    set_in(1, 0, 0, 0, 1, 0, 0);
    cycle();
    cycle();
    RST = 0;

    // single-cycle load
    set_in(0, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    cycle();
    check("LOAD_MDR", MDR_W, 32'hDEADBEEF);

    // non-memory instruction
    set_in(1, 0, 32'h55, 32'h0, 0, 1, 32'hCAFEF00D);
    cycle();
    check("NOMEM_ALU", ALUOUT_W, 32'h55);
    check("NOMEM_MDR", MDR_W, 32'hDEADBEEF);

    // wait-state store, inputs scrambled while waiting
    n_stall = 0;
    set_in(0, 1, 32'h200, 32'h12345678, 1, 0, 32'h0);
    cycle();
    scramble_m(); DRDY = 0; cycle();
    scramble_m(); DRDY = 0; cycle();
    scramble_m(); DRDY = 1; cycle();
    check("STORE_STALLS", 32'(n_stall), 32'd3);

    // timeout then a normal request
    set_in(0, 0, 32'h300, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < TO + 2; i++) begin
      cycle();
      DRDY = 0;
    end
    check("TIMEOUT_ERR", 32'(BUS_ERR), 32'd1);
    check("TIMEOUT_MDR", MDR_W, 32'h0);
    set_in(0, 0, 32'h304, 32'h0, 0, 1, 32'hA5A5A5A5);
    cycle();
    check("POST_TO_MDR", MDR_W, 32'hA5A5A5A5);

    // back-to-back loads
    n_stall = 0;
    n_wb = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 32'h400 + 32'(i * 4), 32'h0, 0, 1, $urandom);
      cycle();
    end
    check("B2B_STALLS", 32'(n_stall), 32'd0);
    check("B2B_WB", 32'(n_wb), 32'd4);

    // reset during the second wait cycle
    set_in(0, 0, 32'h500, 32'h0, 0, 0, 32'h0);
    cycle();
    cycle();
    RST = 1;
    cycle();
    RST = 0;
    check("RST_WAIT_ERR", 32'(BUS_ERR), 32'd0);
    set_in(0, 0, 32'h504, 32'h0, 0, 1, 32'h0BADF00D);
    cycle();

    // random traffic
    stuck = 0;
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1, 1'($urandom), $urandom, $urandom,
             1'($urandom), 1'b0, $urandom);
      if (stuck == 0 && $urandom_range(0, 40) == 0) stuck = $urandom_range(TO, TO + 3);
      if (stuck > 0) begin
        DRDY = 0;
        stuck--;
      end else begin
        DRDY = ($urandom_range(0, 9) < 6);
      end
      RST = ($urandom_range(0, 199) == 0);
      cycle();
    end
    RST = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of wait cycles for one data-memory access before it is aborted.
REQ-002 Parameter AW, default 32, SHALL set the width of DADDR.
REQ-003 Ports SHALL be as follows, one per line: name  direction  width  meaning.
  CLK  in  1  single clock; all state changes on the rising edge.
  RST  in  1  synchronous, active-high reset.
  WEN_M  in  1  register-file write enable, active-low.
  DRW_M  in  1  access type: 1=write (store), 0=read (load).
  DREQ_M  in  1  data-memory request, active-low.
  SelWB_M  in  2  writeback source select.
  WA_M  in  5  writeback register address.
  PCADD4_M  in  32  PC+4.
  ALUOUT_M  in  32  ALU result and memory address.
  DOUT0_M  in  32  store data.
  DREQ  out  1  memory request, active-low.
  DRW  out  1  memory access type.
  DADDR  out  AW  memory address.
  DOUT  out  32  memory write data.
  DI  in  32  memory read data.
  DRDY  in  1  memory ready or acknowledge, active-high.
  STALL_M  out  1  freeze upstream stages, active-high.
  BUS_ERR  out  1  sticky timeout error.
  WEN_W, SelWB_W, WA_W, PCADD4_W, ALUOUT_W  out  1/2/5/32/32  registered copies passed to the writeback stage.
  MDR_W  out  32  registered load data.

Function
REQ-004 The FSM SHALL have two states: IDLE and WAIT.
REQ-005 In IDLE with DREQ_M=0, the block SHALL drive DREQ=0, DRW=DRW_M, DADDR=ALUOUT_M[AW-1:0] and DOUT=DOUT0_M combinationally in the same cycle.
REQ-006 In IDLE with DREQ_M=0 and DRDY=1, the access SHALL complete in a single cycle: STALL_M=0 and the state stays IDLE.
REQ-007 In IDLE with DREQ_M=0 and DRDY=0, the block SHALL assert STALL_M=1 and go to WAIT at the next edge.
REQ-008 In IDLE with DREQ_M=1, the block SHALL drive DREQ=1 and STALL_M=0; DRW, DADDR and DOUT follow their inputs but have no effect.
REQ-009 In WAIT, the block SHALL hold DREQ=0 and SHALL drive DRW, DADDR and DOUT from internally latched copies captured on entry to WAIT, not from the *_M inputs.
REQ-010 In WAIT with DRDY=1, the block SHALL set STALL_M=0, capture the access into the writeback outputs at that edge, and return to IDLE.
REQ-011 In WAIT with DRDY=0, STALL_M SHALL be 1 and a wait counter SHALL increment; the counter width is $clog2(TIMEOUT+1).
REQ-012 When the wait counter reaches TIMEOUT with DRDY still 0, the block SHALL abort:
  - set BUS_ERR=1;
  - drive DREQ=1 and STALL_M=0 in that cycle;
  - return to IDLE;
  - write MDR_W=32'h0;
  - force WEN_W=1 so that no register is written.
REQ-013 BUS_ERR SHALL be cleared only by RST.
REQ-014 The wait counter SHALL clear on every entry to WAIT and on every exit from WAIT.
REQ-015 The writeback register SHALL load WEN_W, SelWB_W, WA_W, PCADD4_W and ALUOUT_W on every edge where STALL_M=0.
REQ-016 MDR_W SHALL load DI only when the completing access is a read (DRW=0); otherwise it SHALL hold its value.
REQ-017 On every edge where STALL_M=1, the writeback register SHALL take a bubble:
  - WEN_W=1;
  - SelWB_W, WA_W, PCADD4_W, ALUOUT_W and MDR_W hold their values.
REQ-018 When a store completes, WEN_W SHALL equal the latched WEN_M unchanged; store instructions are expected to carry WEN_M=1.
REQ-019 DRDY asserted while DREQ=1 SHALL be ignored.
REQ-020 The latency from acceptance to writeback outputs SHALL be 1 cycle plus the number of wait cycles; throughput SHALL be 1 access per cycle when DRDY is continuously 1.

Reset
REQ-021 While RST=1 at an edge, the block SHALL set:
  - state IDLE and wait counter 0;
  - BUS_ERR=0, WEN_W=1, SelWB_W=0, WA_W=0;
  - PCADD4_W=0, ALUOUT_W=0, MDR_W=0;
  - latched DRW, DADDR and DOUT copies to 0.
REQ-022 While RST=1, the block SHALL drive DREQ=1 and STALL_M=0 regardless of the inputs.
REQ-023 RST asserted during WAIT SHALL abandon the access immediately, with no BUS_ERR and no writeback.

Verification
REQ-024 Single-cycle load: DREQ_M=0, DRW_M=0, ALUOUT_M=0x100, DRDY=1, DI=0xDEADBEEF -> DADDR=0x100 and STALL_M=0 that cycle; next cycle MDR_W=0xDEADBEEF and WA_W=WA_M.
REQ-025 Wait-state store: DREQ_M=0, DRW_M=1, DOUT0_M=0x12345678, DRDY low for 3 cycles then high -> STALL_M=1 for exactly 3 cycles; DOUT and DADDR stable throughout even if the *_M inputs change; WEN_W=1 on every bubble edge.
REQ-026 Timeout: TIMEOUT=4 and DRDY held 0 -> BUS_ERR rises after 4 wait cycles; STALL_M drops; WEN_W=1; MDR_W=0; the next request proceeds normally.
REQ-027 Back-to-back loads with DRDY=1 for 4 consecutive requests -> 4 consecutive writeback updates with no STALL_M.
REQ-028 RST=1 in the second WAIT cycle -> the next cycle has DREQ=1, STALL_M=0, WEN_W=1 and BUS_ERR=0; a following request starts from IDLE.
REQ-029 Non-memory instruction: DREQ_M=1, WEN_M=0, ALUOUT_M=0x55 -> DREQ=1; next cycle ALUOUT_W=0x55, WEN_W=0 and MDR_W unchanged.
